// File: rtl/turn_input_cond_pkg.sv
// Shared types for the turn-switch input conditioner.
// Debounce state encoding and default stability window.
package turn_pkg;

  typedef enum logic [1:0] {
    LOW,
    RISE,
    HIGH,
    FALL
  } deb_state_t;

  localparam int DEBOUNCE_DEFAULT = 4;

endpackage

// File: rtl/turn_input_cond_if.sv
// Switch-side bundle between the raw turn switches and the
// tail-light FSM: raw levels in, clean levels/events out.
interface turn_input_cond_if;

  logic left_raw;
  logic right_raw;
  logic left;
  logic right;
  logic left_evt;
  logic right_evt;
  logic hazard;

  modport master (
    output left_raw,
    output right_raw,
    input  left,
    input  right,
    input  left_evt,
    input  right_evt,
    input  hazard
  );

  modport slave (
    input  left_raw,
    input  right_raw,
    output left,
    output right,
    output left_evt,
    output right_evt,
    output hazard
  );

endinterface

// File: rtl/turn_input_cond_debounce.sv
// One switch channel: 2-flop synchronizer, debounce FSM,
// registered clean level and press-event pulse.
module debounce_channel
  import turn_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT,
  parameter int CNT_W = $clog2(DEBOUNCE_CYCLES + 1)
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic level,
  output logic evt,
  output logic level_nxt
);

  localparam logic [CNT_W-1:0] LAST =
    CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             s1;
  logic             s2;
  deb_state_t       state;
  deb_state_t       state_d;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_d;
  logic             evt_d;

  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    unique case (state)
      LOW: begin
        if (s2) begin
          state_d = RISE;
          cnt_d   = '0;
        end
      end
      RISE: begin
        if (!s2) state_d = LOW;
        else if (cnt == LAST) state_d = HIGH;
        else cnt_d = cnt + 1'b1;
      end
      HIGH: begin
        if (!s2) begin
          state_d = FALL;
          cnt_d   = '0;
        end
      end
      FALL: begin
        if (s2) state_d = HIGH;
        else if (cnt == LAST) state_d = LOW;
        else cnt_d = cnt + 1'b1;
      end
      default: begin
        state_d = LOW;
        cnt_d   = '0;
      end
    endcase
  end

  // Level follows the state being entered so it changes on the
  // same edge the FSM accepts the new level.
  assign level_nxt = (state_d == HIGH) || (state_d == FALL);
  assign evt_d     = (state == RISE) && (state_d == HIGH);

  always_ff @(posedge clk) begin
    if (reset) begin
      s1    <= 1'b0;
      s2    <= 1'b0;
      state <= LOW;
      cnt   <= '0;
      level <= 1'b0;
      evt   <= 1'b0;
    end else begin
      s1    <= raw;
      s2    <= s1;
      state <= state_d;
      cnt   <= cnt_d;
      level <= level_nxt;
      evt   <= evt_d;
    end
  end

endmodule

// File: rtl/turn_input_cond.sv
// Turn-switch input conditioner: two debounced channels plus a
// registered hazard flag aligned with the clean levels.
module turn_input_cond
  import turn_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT,
  parameter int CNT_W = $clog2(DEBOUNCE_CYCLES + 1)
) (
  input  logic clk,
  input  logic reset,
  turn_input_cond_if.slave bus
);

  logic left_nxt;
  logic right_nxt;

  debounce_channel #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .CNT_W           (CNT_W)
  ) u_left (
    .clk       (clk),
    .reset     (reset),
    .raw       (bus.left_raw),
    .level     (bus.left),
    .evt       (bus.left_evt),
    .level_nxt (left_nxt)
  );

  debounce_channel #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .CNT_W           (CNT_W)
  ) u_right (
    .clk       (clk),
    .reset     (reset),
    .raw       (bus.right_raw),
    .level     (bus.right),
    .evt       (bus.right_evt),
    .level_nxt (right_nxt)
  );

  always_ff @(posedge clk) begin
    if (reset) bus.hazard <= 1'b0;
    else       bus.hazard <= left_nxt & right_nxt;
  end

endmodule

// File: tb/tb_turn_input_cond.sv
// Directed bench for turn_input_cond with DEBOUNCE_CYCLES = 4.
// Inputs change 1 ns after a rising edge; outputs checked there too.
module tb_turn_input_cond;

  logic clk;
  logic reset;
  int   tests;
  int   fails;

  turn_input_cond_if bus ();

  turn_input_cond #(
    .DEBOUNCE_CYCLES (4)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout reached");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    bus.left_raw  = 1'b0;
    bus.right_raw = 1'b0;
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    logic [4:0] got;
    logic [4:0] exp;
    bus.left_raw  = 1'b1;
    bus.right_raw = 1'b1;
    reset = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      tick();
      got = {bus.left, bus.right, bus.left_evt,
             bus.right_evt, bus.hazard};
      tests++;
      if (got !== 5'b0) begin
        $display("FAIL reset_hold cyc=%0d got=%b exp=00000", i, got);
        fails++;
      end
    end
    reset = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      tick();
      got = {bus.left, bus.right, bus.left_evt,
             bus.right_evt, bus.hazard};
      exp = {(i >= 7), (i >= 7), (i == 7), (i == 7), (i >= 7)};
      tests++;
      if (got !== exp) begin
        $display("FAIL reset_release edge=%0d got=%b exp=%b",
                 i, got, exp);
        fails++;
      end
    end
  endtask

  task automatic test_press();
    logic [3:0] got;
    logic [3:0] exp;
    do_reset();
    bus.left_raw = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      tick();
      got = {bus.left, bus.left_evt, bus.right, bus.hazard};
      exp = {(i >= 7), (i == 7), 1'b0, 1'b0};
      tests++;
      if (got !== exp) begin
        $display("FAIL press edge=%0d got=%b exp=%b", i, got, exp);
        fails++;
      end
    end
    bus.left_raw = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      tick();
      got = {bus.left, bus.left_evt, bus.right, bus.hazard};
      exp = {(i < 7), 1'b0, 1'b0, 1'b0};
      tests++;
      if (got !== exp) begin
        $display("FAIL release edge=%0d got=%b exp=%b", i, got, exp);
        fails++;
      end
    end
  endtask

  task automatic test_glitch();
    logic [1:0] got;
    logic [1:0] exp;
    do_reset();
    bus.right_raw = 1'b1;
    for (int i = 1; i <= 15; i++) begin
      if (i == 4) bus.right_raw = 1'b0;
      tick();
      got = {bus.right, bus.right_evt};
      tests++;
      if (got !== 2'b00) begin
        $display("FAIL glitch_high edge=%0d got=%b exp=00", i, got);
        fails++;
      end
    end
    bus.right_raw = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      tick();
      got = {bus.right, bus.right_evt};
      exp = {(i >= 7), (i == 7)};
      tests++;
      if (got !== exp) begin
        $display("FAIL glitch_setup edge=%0d got=%b exp=%b",
                 i, got, exp);
        fails++;
      end
    end
    bus.right_raw = 1'b0;
    for (int i = 1; i <= 15; i++) begin
      if (i == 3) bus.right_raw = 1'b1;
      tick();
      got = {bus.right, bus.right_evt};
      tests++;
      if (got !== 2'b10) begin
        $display("FAIL glitch_low edge=%0d got=%b exp=10", i, got);
        fails++;
      end
    end
  endtask

  task automatic test_bounce();
    logic [4:0] pat;
    logic [1:0] got;
    logic [1:0] exp;
    int         evts;
    do_reset();
    pat  = 5'b10101;
    evts = 0;
    for (int k = 4; k >= 1; k--) begin
      bus.left_raw = pat[k];
      tick();
      evts += int'(bus.left_evt);
      got = {bus.left, bus.left_evt};
      tests++;
      if (got !== 2'b00) begin
        $display("FAIL bounce_toggle step=%0d got=%b exp=00",
                 4 - k, got);
        fails++;
      end
    end
    bus.left_raw = pat[0];
    for (int i = 1; i <= 12; i++) begin
      tick();
      evts += int'(bus.left_evt);
      got = {bus.left, bus.left_evt};
      exp = {(i >= 7), (i == 7)};
      tests++;
      if (got !== exp) begin
        $display("FAIL bounce_settle edge=%0d got=%b exp=%b",
                 i, got, exp);
        fails++;
      end
    end
    tests++;
    if (evts != 1) begin
      $display("FAIL bounce_evt_count got=%0d exp=1", evts);
      fails++;
    end
  endtask

  task automatic test_independent();
    logic [2:0] got;
    logic [2:0] exp;
    do_reset();
    bus.left_raw = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      tick();
      if (i == 2) bus.right_raw = 1'b1;
      got = {bus.left, bus.right, bus.hazard};
      exp = {(i >= 7), (i >= 9), (i >= 9)};
      tests++;
      if (got !== exp) begin
        $display("FAIL indep_press edge=%0d got=%b exp=%b",
                 i, got, exp);
        fails++;
      end
    end
    bus.left_raw = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      tick();
      got = {bus.left, bus.right, bus.hazard};
      exp = {(i < 7), 1'b1, (i < 7)};
      tests++;
      if (got !== exp) begin
        $display("FAIL indep_release edge=%0d got=%b exp=%b",
                 i, got, exp);
        fails++;
      end
    end
  endtask

  task automatic test_mid_reset();
    logic [1:0] got;
    logic [1:0] exp;
    do_reset();
    bus.left_raw = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      tick();
      tests++;
      if (bus.left !== 1'b0) begin
        $display("FAIL mid_pre edge=%0d got=%b exp=0", i, bus.left);
        fails++;
      end
    end
    reset = 1'b1;
    tick();
    tests++;
    if (bus.left !== 1'b0) begin
      $display("FAIL mid_reset got=%b exp=0", bus.left);
      fails++;
    end
    reset = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      tick();
      got = {bus.left, bus.left_evt};
      exp = {(i >= 7), (i == 7)};
      tests++;
      if (got !== exp) begin
        $display("FAIL mid_after edge=%0d got=%b exp=%b",
                 i, got, exp);
        fails++;
      end
    end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    reset = 1'b1;
    bus.left_raw  = 1'b0;
    bus.right_raw = 1'b0;
    @(negedge clk);
    test_reset();
    test_press();
    test_glitch();
    test_bounce();
    test_independent();
    test_mid_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/turn_input_cond.md
# turn_input_cond

Input conditioner directly upstream of the tail-light `FSM`. Takes the raw, asynchronous left/right turn-switch levels and synchronizes each into `clk`. It debounces each channel with a small per-channel state machine and delivers clean `left`/`right` levels to the FSM's `left`/`right` inputs, plus one-cycle press-event pulses and a hazard flag (both switches held).

## Interface
Parameters:
- `DEBOUNCE_CYCLES`, default 4: consecutive stable cycles required before a level change is accepted. Legal range ≥ 1.
- `CNT_W`, default `$clog2(DEBOUNCE_CYCLES+1)`: debounce counter width. Derived; not overridden.

Ports:
- `clk`  in  1: single clock. Everything is on the rising edge.
- `reset`  in  1: synchronous, active-high. One clock; reset is synchronous and active-high.
- `left_raw`  in  1: raw left switch, asynchronous to `clk`.
- `right_raw`  in  1: raw right switch, asynchronous to `clk`.
- `left`  out  1: debounced left level. Feeds `FSM.left`.
- `right`  out  1: debounced right level. Feeds `FSM.right`.
- `left_evt`  out  1: one-cycle pulse on each accepted 0→1 of `left`.
- `right_evt`  out  1: one-cycle pulse on each accepted 0→1 of `right`.
- `hazard`  out  1: `left & right`, registered.

## Operation
- **Synchronizer:** a 2-flop synchronizer per channel, `s1` then `s2`. Both flops reset to 0.
- **Per-channel debounce FSM:** states `LOW`, `RISE`, `HIGH`, `FALL`. Counter `cnt` is `CNT_W` bits.
  - `LOW`: if `s2`=1, go to `RISE` and clear `cnt`. Otherwise stay.
  - `RISE`: if `s2`=0, return to `LOW` (glitch rejected). Else if `cnt`==`DEBOUNCE_CYCLES-1`, go to `HIGH`. Else increment `cnt`.
  - `HIGH`: if `s2`=0, go to `FALL` and clear `cnt`.
  - `FALL`: if `s2`=1, return to `HIGH`. Else if `cnt`==`DEBOUNCE_CYCLES-1`, go to `LOW`. Else increment `cnt`.
- **Outputs:**
  - Level output is a register. It is 1 exactly when the state is `HIGH` or `FALL`.
  - `*_evt` is a register. It is 1 for the single cycle following the `RISE`→`HIGH` transition.
  - `hazard` is registered from the next-cycle values of `left` and `right`, so it is aligned with them.
- **Counter bound:** `cnt` never exceeds `DEBOUNCE_CYCLES-1`. No wrap is possible.
- **Independence:** channels are fully independent. Simultaneous changes on both channels are each processed with no priority. Both high is passed through; the FSM treats that as hazard.
- **Reset:**
  - On any edge with `reset`=1: sync flops, states, counters and all outputs go to 0 (state `LOW`).
  - Reset mid-debounce discards the partial count.
  - A raw input already high when reset deasserts is then debounced normally from `LOW`.

## Timing
- **Reset values:** `left`=`right`=`left_evt`=`right_evt`=`hazard`=0.
- **Rise latency:** raw level change first sampled at edge E0, then held stable.
  - `s2` updates at E1.
  - The FSM leaves `LOW` at E2.
  - It enters `HIGH` at E2+`DEBOUNCE_CYCLES`.
  - The output rises at that same edge, i.e. `DEBOUNCE_CYCLES`+3 edges counting E0. With the default, that is 7 edges (70 ns at a 10 ns clock).
  - `*_evt` is high during the cycle after that edge only.
- **Fall latency:** identical; no event pulse on fall.
- **Glitch filtering:** a raw pulse (high or low) that yields fewer than `DEBOUNCE_CYCLES` consecutive equal `s2` samples causes no output change.
- **No combinational paths:** no combinational path exists from any input to any output.

## Structure
- **Shared package `turn_pkg`:**
  - `typedef enum logic [1:0] {LOW, RISE, HIGH, FALL} deb_state_t`.
  - Default debounce constant `DEBOUNCE_DEFAULT = 4`.
- **Sub-module `debounce_channel`:** one sub-module containing the synchronizer, the debounce FSM, the counter, and the level and event registers. It is instantiated twice.
- **Top level:** `turn_input_cond` adds only the `hazard` register.

## Test plan
All scenarios use `DEBOUNCE_CYCLES`=4 and a 10 ns clock.
1. **Reset:** hold `reset`=1 for 8 cycles with `left_raw`=`right_raw`=1 → all outputs 0 throughout. After deassert, `left`/`right` rise 7 edges later. `left_evt`/`right_evt` pulse for exactly 1 cycle. `hazard`=1 in the same cycle `left`/`right` rise.
2. **Clean press/release:** `left_raw` 0→1 held for 20 cycles, then 1→0 → `left` rises 7 edges after the first sampling edge and falls 7 edges after release. `left_evt` is a single 1-cycle pulse. `right` and `hazard` stay 0.
3. **Glitch rejection:**
   - A 3-cycle high pulse on `right_raw` → `right`, `right_evt` stay 0.
   - With `right` high, a 2-cycle low dropout → `right` stays 1 and no second `right_evt`.
4. **Bounce:** `left_raw` toggles 1,0,1,0,1 one cycle apart, then holds 1 → exactly one `left_evt`. `left` rises 7 edges after the final 0→1.
5. **Independent channels:** press `left_raw` at cycle 0 and `right_raw` at cycle 2 → `left` rises at edge 7 and `right` at edge 9. `hazard` rises at edge 9. Releasing `left` drops `hazard` in the same cycle `left` falls.
6. **Reset mid-debounce:** `left_raw`=1 for 4 cycles, then pulse `reset` for 1 cycle → `left` stays 0 through the reset. It rises 7 edges after the first post-reset sampling edge.
